// File: rtl/niosqs_nios2_qsys_0_cpu_div_cell.sv
// niosqs_nios2_qsys_0_cpu_div_cell: 32-bit signed/unsigned radix-2 restoring divider with fixed latency
module niosqs_nios2_qsys_0_cpu_div_cell (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        E_div_start,
  input  logic        E_div_signed,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_quotient,
  output logic [31:0] M_div_remainder,
  output logic        M_div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        warm;
  logic [31:0] b, q, r;
  logic        q_neg, r_neg, dz;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sh, sub;
  logic        ge;
  // operand magnitudes and one restoring step on the 33-bit shifted partial remainder
  always_comb begin
    a_neg = E_div_signed & E_src1[31];
    b_neg = E_div_signed & E_src2[31];
    a_mag = a_neg ? -E_src1 : E_src1;
    b_mag = b_neg ? -E_src2 : E_src2;
    sh    = {r, q[31]};
    sub   = sh - {1'b0, b};
    ge    = sh >= {1'b0, b};
  end
  // control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      warm            <= 1'b0;
      b               <= '0;
      q               <= '0;
      r               <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dz              <= 1'b0;
      M_div_busy      <= 1'b0;
      M_div_done      <= 1'b0;
      M_div_quotient  <= '0;
      M_div_remainder <= '0;
      M_div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (E_div_start) begin
          q          <= a_mag;
          r          <= '0;
          b          <= b_mag;
          q_neg      <= a_neg ^ b_neg;
          r_neg      <= a_neg;
          dz         <= E_src2 == '0;
          cnt        <= '0;
          warm       <= 1'b1;
          M_div_busy <= 1'b1;
          state      <= RUN;
        end
        RUN: if (warm) warm <= 1'b0;
        else begin
          q     <= {q[30:0], ge};
          r     <= ge ? sub[31:0] : sh[31:0];
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : RUN;
        end
        FIX: begin
          M_div_quotient  <= dz ? '1 : q_neg ? -q : q;
          M_div_remainder <= r_neg ? -r : r;
          M_div_by_zero   <= dz;
          M_div_busy      <= 1'b0;
          M_div_done      <= 1'b1;
          state           <= DONE;
        end
        default: begin
          M_div_done <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_niosqs_nios2_qsys_0_cpu_div_cell.sv
// tb_niosqs_nios2_qsys_0_cpu_div_cell: scoreboard bench against an arithmetic division model
module tb_niosqs_nios2_qsys_0_cpu_div_cell;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] E_src1 = '0, E_src2 = '0;
  logic        E_div_start = 1'b0, E_div_signed = 1'b0;
  logic        M_div_busy, M_div_done, M_div_by_zero;
  logic [31:0] M_div_quotient, M_div_remainder;
  niosqs_nios2_qsys_0_cpu_div_cell dut (
    .clk(clk), .reset(reset), .E_src1(E_src1), .E_src2(E_src2),
    .E_div_start(E_div_start), .E_div_signed(E_div_signed),
    .M_div_busy(M_div_busy), .M_div_done(M_div_done),
    .M_div_quotient(M_div_quotient), .M_div_remainder(M_div_remainder),
    .M_div_by_zero(M_div_by_zero)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] q, r; logic dz; int n;} exp_t;
  exp_t sb[$];
  exp_t got;
  int compared = 0, mismatched = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg, input int n);
    exp_t e;
    longint x, y;
    e.n  = n;
    e.dz = b == 0;
    if (b == 0) begin
      e.q = 32'hFFFFFFFF;
      e.r = a;
    end else begin
      x = sg ? longint'($signed(a)) : longint'({32'b0, a});
      y = sg ? longint'($signed(b)) : longint'({32'b0, b});
      e.q = 32'(x / y);
      e.r = 32'(x % y);
    end
    return e;
  endfunction
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) if (M_div_done) begin
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
    end else begin
      got = sb.pop_front();
      chk("quotient", M_div_quotient, got.q);
      chk("remainder", M_div_remainder, got.r);
      chk("by_zero", {31'b0, M_div_by_zero}, {31'b0, got.dz});
      chk("latency", cyc, got.n + 34);
      chk("busy_at_done", {31'b0, M_div_busy}, 32'd0);
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg, input bit push);
    @(negedge clk);
    E_src1 = a;
    E_src2 = b;
    E_div_signed = sg;
    E_div_start = 1'b1;
    if (push) sb.push_back(model(a, b, sg, cyc + 1));
    @(negedge clk);
    E_div_start = 1'b0;
    chk("busy_after_start", {31'b0, M_div_busy}, 32'd1);
  endtask
  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && (sb.size() != 0 || M_div_busy || M_div_done); i++) @(negedge clk);
    if (i == 100) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, M_div_busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, M_div_done}, 32'd0);
    chk({tag, "_by_zero"}, {31'b0, M_div_by_zero}, 32'd0);
    chk({tag, "_quotient"}, M_div_quotient, 32'd0);
    chk({tag, "_remainder"}, M_div_remainder, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] b;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    issue(100, 7, 0, 1); wait_idle();
    issue(32'hFFFFFFFF, 1, 0, 1); wait_idle();
    issue(-32'sd7, 2, 1, 1); wait_idle();
    issue(7, -32'sd2, 1, 1); wait_idle();
    issue(5, 0, 1, 1); wait_idle();
    issue(5, 0, 0, 1); wait_idle();
    issue(32'h80000000, 32'hFFFFFFFF, 1, 1); wait_idle();
    issue(32'h80000000, 0, 1, 1); wait_idle();
    @(negedge clk);
    E_src1 = 1000; E_src2 = 7; E_div_signed = 1'b0; E_div_start = 1'b1;
    n = cyc + 1;
    sb.push_back(model(1000, 7, 0, n));
    repeat (36) @(negedge clk);
    E_src1 = -32'sd1000; E_src2 = 33; E_div_signed = 1'b1;
    sb.push_back(model(-32'sd1000, 33, 1, n + 36));
    @(negedge clk);
    E_div_start = 1'b0;
    wait_idle();
    issue(32'h12345678, 77, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(9, 3, 0, 1); wait_idle();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue($urandom, b, 1'($urandom_range(0, 1)), 1);
      wait_idle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
